// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the accumulator write arbiter.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;

  // Requester slots on the accumulator write port
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_IMM = 2;
  localparam int REQ_IO  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/acc_write_arbiter_rr_pick.sv
// Round-robin picker: rotate eligible so rr_ptr sits at bit 0, take the
// lowest set bit, then rotate the index back into requester space.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [N-1:0] rot;
  int           pos;
  int           sum;

  // Rotate, priority-encode from bit 0, rotate back modulo N
  always_comb begin
    rot   = N'({eligible, eligible} >> rr_ptr);
    found = |rot;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    sum = pos + int'(rr_ptr);
    if (sum >= N) sum = sum - N;
    winner = IDX_W'(sum);
  end

endmodule

// File: rtl/acc_write_arbiter.sv
// Shares the accumulator write port among NUM_REQ requesters. Each granted
// write is a one-cycle acc_enable pulse carrying data registered at the
// grant edge; a requester holding req_lock keeps the port for a burst.
module acc_write_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          hold,
  output logic [NUM_REQ-1:0]            ack,
  output logic [IDX_W-1:0]              gnt_idx,
  output logic                          busy,
  output logic                          acc_enable,
  output logic [DATA_WIDTH-1:0]         acc_data
);

  arb_state_t              state, state_nx;
  logic [IDX_W-1:0]        rr_ptr, gnt_q, nxt_ptr, pick_ptr, win_idx;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    lock_q;   // owner asked for lock at its grant edge
  logic                    wr_q;     // LOCKED: a burst write is on the port now
  logic                    win_found, take_win, take_own, wr_nx, owner;
  logic [NUM_REQ-1:0]      eligible;
  logic [DATA_WIDTH-1:0]   lane_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A GRANT cycle already moves the pointer past the owner, so back-to-back
  // arbitration must see the advanced pointer, not the stale register.
  assign nxt_ptr  = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
  assign pick_ptr = (state == GRANT) ? nxt_ptr : rr_ptr;
  // The requester being acked still shows req this cycle; ignore it.
  assign eligible = req & ~ack;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (eligible),
    .rr_ptr   (pick_ptr),
    .winner   (win_idx),
    .found    (win_found)
  );

  // State, pointer and write-data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_q  <= '0;
      data_q <= '0;
      lock_q <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      state <= state_nx;
      wr_q  <= wr_nx;
      if (state == GRANT) rr_ptr <= nxt_ptr;
      if (take_win) begin
        gnt_q  <= win_idx;
        data_q <= lane_data[win_idx];
        lock_q <= req_lock[win_idx];
      end else if (take_own) begin
        data_q <= lane_data[gnt_q];
        lock_q <= 1'b0;
      end
    end
  end

  // Next state: the lock owner decides alone; otherwise rearbitrate
  always_comb begin
    state_nx = state;
    take_win = 1'b0;
    take_own = 1'b0;
    wr_nx    = 1'b0;
    owner    = (state == LOCKED) || (state == GRANT && lock_q);
    if (owner) begin
      if (hold) begin
        state_nx = LOCKED;
      end else if (req[gnt_q]) begin
        take_own = 1'b1;
        if (req_lock[gnt_q]) begin
          state_nx = LOCKED;
          wr_nx    = 1'b1;
        end else begin
          state_nx = GRANT;   // last write of the burst, then rearbitrate
        end
      end else begin
        state_nx = req_lock[gnt_q] ? LOCKED : IDLE;
      end
    end else if (!hold && win_found) begin
      state_nx = GRANT;
      take_win = 1'b1;
    end else begin
      state_nx = IDLE;
    end
  end

  // Outputs: ack and acc_enable are asserted together from the same term
  always_comb begin
    ack        = '0;
    acc_enable = (state == GRANT) || (state == LOCKED && wr_q);
    if (acc_enable) ack[gnt_q] = 1'b1;
    busy       = (state != IDLE);
    gnt_idx    = gnt_q;
    acc_data   = data_q;
  end

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Bench for acc_write_arbiter: directed scenarios plus a randomized run
// checked against a pending-set / last-winner round-robin model.
module tb_acc_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk, reset, hold;
  logic [N-1:0]    req, req_lock, ack;
  logic [N*DW-1:0] req_data;
  logic [IW-1:0]   gnt_idx;
  logic            busy, acc_enable;
  logic [DW-1:0]   acc_data;

  int checks   = 0;
  int failures = 0;

  acc_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_lock   (req_lock),
    .req_data   (req_data),
    .hold       (hold),
    .ack        (ack),
    .gnt_idx    (gnt_idx),
    .busy       (busy),
    .acc_enable (acc_enable),
    .acc_data   (acc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge; outputs are sampled on negedge.
  task automatic do_reset;
    reset    = 1'b0;
    req      = '0;
    req_lock = '0;
    hold     = 1'b0;
    req_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic test_reset;
    reset = 1'b0; req = '0; req_lock = '0; hold = 1'b0; req_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (acc_enable !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", acc_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (gnt_idx !== 2'd0) begin failures++; $display("FAIL reset_gnt got=%0d exp=0", gnt_idx); end
    checks++; if (acc_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", acc_data); end
    reset = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001; set_data(0, 16'hAAAA);
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", ack); end
    checks++; if (acc_enable !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", acc_enable); end
    checks++; if (acc_data !== 16'hAAAA) begin failures++; $display("FAIL single_data got=%h exp=aaaa", acc_data); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL single_idle_ack got=%b exp=0000", ack); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, DW'(32'h1000 + i));
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      checks++; if (ack !== N'(1 << k)) begin failures++; $display("FAIL b2b_ack%0d got=%b exp=%b", k, ack, N'(1 << k)); end
      checks++; if (acc_data !== DW'(32'h1000 + k)) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", k, acc_data, DW'(32'h1000 + k)); end
      if (k > 0) req[k-1] = 1'b0;
    end
    req[N-1] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL b2b_idle busy=%b ack=%b exp busy=0 ack=0000", busy, ack); end
  endtask

  task automatic test_lock;
    int f0_writes;
    do_reset();
    f0_writes = 0;
    req = 4'b1010; req_lock = 4'b0010;
    set_data(1, 16'hF0F0); set_data(3, 16'h3333);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL lock_ack%0d got=%b exp=0010", c, ack); end
      checks++; if (acc_data !== 16'hF0F0 || gnt_idx !== 2'd1) begin failures++; $display("FAIL lock_data%0d got=%h/%0d exp=f0f0/1", c, acc_data, gnt_idx); end
      if (ack == 4'b0010 && acc_data == 16'hF0F0) f0_writes++;
      if (c == 2) req_lock = 4'b0000;
      if (c == 3) req[1] = 1'b0;
    end
    @(negedge clk);
    checks++; if (ack !== 4'b1000 || acc_data !== 16'h3333) begin failures++; $display("FAIL lock_next got=%b/%h exp=1000/3333", ack, acc_data); end
    checks++; if (f0_writes !== 3) begin failures++; $display("FAIL lock_count got=%0d exp=3", f0_writes); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lock_idle got=%b exp=0", busy); end
  endtask

  task automatic test_hold;
    do_reset();
    hold = 1'b1; req = 4'b0100; set_data(2, 16'h2222);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (ack !== 4'b0000 || acc_enable !== 1'b0) begin failures++; $display("FAIL hold_block%0d ack=%b en=%b exp 0000/0", c, ack, acc_enable); end
    end
    hold = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 4'b0100 || acc_data !== 16'h2222) begin failures++; $display("FAIL hold_release got=%b/%h exp=0100/2222", ack, acc_data); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    req = 4'b0001; set_data(0, 16'h5555);
    @(negedge clk);
    checks++; if (acc_enable !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", acc_enable); end
    #1 reset = 1'b0;
    #1;
    checks++; if (ack !== 4'b0000 || acc_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async ack=%b en=%b busy=%b exp 0000/0/0", ack, acc_enable, busy); end
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0000 || acc_enable !== 1'b0 || acc_data !== 16'h0000) begin failures++; $display("FAIL rst_mid_after ack=%b en=%b data=%h exp zeros", ack, acc_enable, acc_data); end
    // rr_ptr back at 0: requester 0 wins over 1
    req = 4'b0011; set_data(0, 16'h0001); set_data(1, 16'h0002);
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rst_mid_ptr got=%b exp=0001", ack); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_withdraw;
    do_reset();
    hold = 1'b1; req = 4'b0001; set_data(0, 16'h7777);
    @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    hold = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ack !== 4'b0000 || acc_enable !== 1'b0 || acc_data !== 16'h0000) begin failures++; $display("FAIL withdraw%0d ack=%b en=%b data=%h exp zeros", c, ack, acc_enable, acc_data); end
    end
  endtask

  // Model: pending set of requesters; each free cycle without hold, the
  // next write goes to the first pending requester after the last winner.
  task automatic test_random;
    int            last;
    logic [N-1:0]  pend, exp_ack, prev_ack;
    logic [DW-1:0] exp_data;
    logic          hit;
    do_reset();
    last = N - 1; pend = '0; exp_ack = '0; prev_ack = '0; exp_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) if (prev_ack[i]) req[i] = 1'b0;
      for (int i = 0; i < N; i++) if (exp_ack[i]) pend[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !pend[i] && !prev_ack[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; req[i] = 1'b1; set_data(i, DW'($urandom));
        end
      end
      hold     = ($urandom_range(0, 3) == 0);
      prev_ack = exp_ack;
      exp_ack  = '0;
      hit      = 1'b0;
      if (!hold) begin
        for (int k = 1; k <= N; k++) begin
          if (!hit && pend[(last + k) % N]) begin
            hit = 1'b1;
            last = (last + k) % N;
            exp_ack[last] = 1'b1;
            exp_data = req_data[last*DW +: DW];
          end
        end
      end
      @(negedge clk);
      checks++; if (ack !== exp_ack) begin failures++; $display("FAIL rnd_ack c%0d got=%b exp=%b", cyc, ack, exp_ack); end
      checks++; if (acc_enable !== (exp_ack != '0)) begin failures++; $display("FAIL rnd_en c%0d got=%b exp=%b", cyc, acc_enable, exp_ack != '0); end
      if (exp_ack != '0) begin
        checks++; if (acc_data !== exp_data) begin failures++; $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, acc_data, exp_data); end
      end
    end
    req = '0; hold = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lock();
    test_hold();
    test_reset_mid_write();
    test_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
